// File: rtl/ysyx_22041207_me_lsu.sv
// Memory-stage load/store unit: one AXI4-Lite transaction per load or store.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   addr, memoryReadWen,   - memory-access fields from the EX/ME register
//   readNum, sext,
//   memoryWriteMask, wdata_in
//   me_wait_for_axi        - combinational stall to EX/ME and upstream
//   load_data, load_valid  - extended load result and completion pulse
//   bus_err                - completion pulse for a non-OKAY response
//   ar*/r*/aw*/w*/b*       - AXI4-Lite master channels
module ysyx_22041207_me_lsu #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       addr,
    input  logic              memoryReadWen,
    input  logic [3:0]        readNum,
    input  logic              sext,
    input  logic [7:0]        memoryWriteMask,
    input  logic [63:0]       wdata_in,
    output logic              me_wait_for_axi,
    output logic [63:0]       load_data,
    output logic              load_valid,
    output logic              bus_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [63:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [63:0]       wdata,
    output logic [7:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned LANE_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW_W,
        S_B,
        S_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                aw_done_q;
    logic                aw_done_d;
    logic                w_done_q;
    logic                w_done_d;
    logic                req_c;
    logic                leave_idle_c;
    logic                rd_capture_c;
    logic                err_d;
    logic [LANE_W-1:0]   lane_q;
    logic [3:0]          read_num_q;
    logic                sext_q;
    logic [DATA_W-1:0]   shifted_c;
    logic [DATA_W-1:0]   extended_c;
    logic                unused_addr_bits;

    assign req_c = memoryReadWen | (|memoryWriteMask);
    assign leave_idle_c = (state_q == S_IDLE) && (state_d != S_IDLE);
    assign unused_addr_bits = ^addr;

    // Stall holds EX/ME for the whole transaction; DONE lets the next instruction in.
    assign me_wait_for_axi = ((state_q == S_IDLE) && req_c) ||
                             (state_q == S_AR) || (state_q == S_R) ||
                             (state_q == S_AW_W) || (state_q == S_B);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Next-state logic; read wins when both a load and a store are requested
    always_comb begin
        state_d      = state_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        rd_capture_c = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (memoryReadWen) begin
                    state_d = S_AR;
                end else if (|memoryWriteMask) begin
                    state_d = S_AW_W;
                end
            end
            S_AR: begin
                if (arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (rvalid) begin
                    rd_capture_c = 1'b1;
                    err_d        = |rresp;
                    state_d      = S_DONE;
                end
            end
            S_AW_W: begin
                if (awvalid && awready) begin
                    aw_done_d = 1'b1;
                end
                if (wvalid && wready) begin
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = S_B;
                end
            end
            S_B: begin
                if (bvalid) begin
                    err_d   = |bresp;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Channel handshake outputs, registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            load_valid <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            arvalid    <= (state_d == S_AR);
            rready     <= (state_d == S_R);
            awvalid    <= (state_d == S_AW_W) && !aw_done_d;
            wvalid     <= (state_d == S_AW_W) && !w_done_d;
            bready     <= (state_d == S_B);
            load_valid <= rd_capture_c;
            bus_err    <= err_d;
        end
    end

    // Request payload captured once when the transaction starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            araddr     <= '0;
            awaddr     <= '0;
            wdata      <= '0;
            wstrb      <= '0;
            lane_q     <= '0;
            read_num_q <= '0;
            sext_q     <= 1'b0;
        end else if (leave_idle_c) begin
            araddr     <= {addr[ADDR_W-1:LANE_W], LANE_W'(0)};
            awaddr     <= {addr[ADDR_W-1:LANE_W], LANE_W'(0)};
            wdata      <= wdata_in << {addr[LANE_W-1:0], 3'b000};
            wstrb      <= memoryWriteMask;
            lane_q     <= addr[LANE_W-1:0];
            read_num_q <= readNum;
            sext_q     <= sext;
        end
    end

    assign shifted_c = rdata >> {lane_q, 3'b000};

    // Truncate to the access size, then sign- or zero-extend
    always_comb begin
        extended_c = shifted_c;
        case (read_num_q)
            4'd1: extended_c = {{56{sext_q & shifted_c[7]}},  shifted_c[7:0]};
            4'd2: extended_c = {{48{sext_q & shifted_c[15]}}, shifted_c[15:0]};
            4'd4: extended_c = {{32{sext_q & shifted_c[31]}}, shifted_c[31:0]};
            default: extended_c = shifted_c;
        endcase
    end

    // Load result; an error response returns zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_data <= '0;
        end else if (rd_capture_c) begin
            load_data <= (|rresp) ? DATA_W'(0) : extended_c;
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_me_lsu.sv
// Self-checking bench for the memory-stage LSU with a scripted AXI4-Lite slave.
module tb_ysyx_22041207_me_lsu;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [63:0]       addr;
    logic              memoryReadWen;
    logic [3:0]        readNum;
    logic              sext;
    logic [7:0]        memoryWriteMask;
    logic [63:0]       wdata_in;
    logic              me_wait_for_axi;
    logic [63:0]       load_data;
    logic              load_valid;
    logic              bus_err;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [63:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit                is_load;
        logic [ADDR_W-1:0] axaddr;
        logic [63:0]       data;
        logic [7:0]        strb;
        bit                err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ysyx_22041207_me_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .addr            (addr),
        .memoryReadWen   (memoryReadWen),
        .readNum         (readNum),
        .sext            (sext),
        .memoryWriteMask (memoryWriteMask),
        .wdata_in        (wdata_in),
        .me_wait_for_axi (me_wait_for_axi),
        .load_data       (load_data),
        .load_valid      (load_valid),
        .bus_err         (bus_err),
        .araddr          (araddr),
        .arvalid         (arvalid),
        .arready         (arready),
        .rdata           (rdata),
        .rresp           (rresp),
        .rvalid          (rvalid),
        .rready          (rready),
        .awaddr          (awaddr),
        .awvalid         (awvalid),
        .awready         (awready),
        .wdata           (wdata),
        .wstrb           (wstrb),
        .wvalid          (wvalid),
        .wready          (wready),
        .bresp           (bresp),
        .bvalid          (bvalid),
        .bready          (bready)
    );

    function automatic exp_t mk(input bit ld, input logic [ADDR_W-1:0] a,
                                input logic [63:0] d, input logic [7:0] s, input bit e);
        exp_t r;
        r.is_load = ld;
        r.axaddr  = a;
        r.data    = d;
        r.strb    = s;
        r.err     = e;
        return r;
    endfunction

    task automatic clear_inputs();
        addr            = '0;
        memoryReadWen   = 1'b0;
        readNum         = '0;
        sext            = 1'b0;
        memoryWriteMask = '0;
        wdata_in        = '0;
    endtask

    task automatic clear_slave();
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = '0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = '0;
    endtask

    // Presents one request, plays the slave with the given per-channel delays,
    // and pops the scoreboard when the unit reaches its completion cycle.
    task automatic run_txn(input string name, input logic [63:0] a, input bit rd,
                           input logic [3:0] rn, input bit sx, input logic [7:0] mask,
                           input logic [63:0] wd, input logic [63:0] rdv, input logic [1:0] resp,
                           input int ar_d, input int r_d, input int aw_d, input int w_d,
                           input int b_d, input exp_t e,
                           output int waits, output bit saw_aw, output int aw_last,
                           output int w_last, output int b_hs);
        int   ar_cnt = 0;
        int   r_cnt  = 0;
        int   aw_cnt = 0;
        int   w_cnt  = 0;
        int   b_cnt  = 0;
        bit   done   = 1'b0;
        exp_t got;
        waits   = 0;
        saw_aw  = 1'b0;
        aw_last = -1;
        w_last  = -1;
        b_hs    = 0;
        @(negedge clk);
        addr            = a;
        memoryReadWen   = rd;
        readNum         = rn;
        sext            = sx;
        memoryWriteMask = mask;
        wdata_in        = wd;
        sb.push_back(e);
        #1;
        checks++;
        if (me_wait_for_axi !== 1'b1)
            $display("FAIL %s wait_on_req: got %b expected 1", name, me_wait_for_axi);
        if (me_wait_for_axi !== 1'b1) failures++;
        waits = 1;
        for (int cyc = 1; cyc < 80 && !done; cyc++) begin
            @(negedge clk);
            if (me_wait_for_axi) waits++;
            if (arvalid) begin
                checks++;
                if (araddr !== e.axaddr) begin
                    failures++;
                    $display("FAIL %s araddr: got %h expected %h", name, araddr, e.axaddr);
                end
            end
            if (awvalid) begin
                saw_aw  = 1'b1;
                aw_last = cyc;
                checks++;
                if (awaddr !== e.axaddr) begin
                    failures++;
                    $display("FAIL %s awaddr: got %h expected %h", name, awaddr, e.axaddr);
                end
            end
            if (wvalid) begin
                w_last = cyc;
                checks++;
                if (wdata !== e.data || wstrb !== e.strb) begin
                    failures++;
                    $display("FAIL %s wdata/wstrb: got %h/%h expected %h/%h",
                             name, wdata, wstrb, e.data, e.strb);
                end
            end
            if (!me_wait_for_axi) begin
                done = 1'b1;
                got  = sb.pop_front();
                checks++;
                if (load_valid !== got.is_load) begin
                    failures++;
                    $display("FAIL %s load_valid: got %b expected %b", name, load_valid, got.is_load);
                end
                checks++;
                if (bus_err !== got.err) begin
                    failures++;
                    $display("FAIL %s bus_err: got %b expected %b", name, bus_err, got.err);
                end
                if (got.is_load) begin
                    checks++;
                    if (load_data !== got.data) begin
                        failures++;
                        $display("FAIL %s load_data: got %h expected %h", name, load_data, got.data);
                    end
                end
            end
            arready = arvalid && (ar_cnt >= ar_d);
            ar_cnt  = arvalid ? ar_cnt + 1 : 0;
            rvalid  = rready && (r_cnt >= r_d);
            rdata   = rvalid ? rdv : 64'd0;
            rresp   = rvalid ? resp : 2'b00;
            r_cnt   = rready ? r_cnt + 1 : 0;
            awready = awvalid && (aw_cnt >= aw_d);
            aw_cnt  = awvalid ? aw_cnt + 1 : 0;
            wready  = wvalid && (w_cnt >= w_d);
            w_cnt   = wvalid ? w_cnt + 1 : 0;
            bvalid  = bready && (b_cnt >= b_d);
            bresp   = bvalid ? resp : 2'b00;
            b_cnt   = bready ? b_cnt + 1 : 0;
            if (bvalid) b_hs++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: no completion within 80 cycles", name);
            sb.delete();
        end
        clear_inputs();
        clear_slave();
        @(negedge clk);
        checks++;
        if (load_valid !== 1'b0 || bus_err !== 1'b0 || me_wait_for_axi !== 1'b0 ||
            arvalid !== 1'b0 || awvalid !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: lv=%b err=%b wait=%b arv=%b awv=%b expected all 0",
                     name, load_valid, bus_err, me_wait_for_axi, arvalid, awvalid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        clear_slave();
        repeat (2) @(negedge clk);
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready, load_valid, bus_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_handshakes: got %b expected 0000000",
                     {arvalid, rready, awvalid, wvalid, bready, load_valid, bus_err});
        end
        checks++;
        if (load_data !== 64'd0 || araddr !== '0 || awaddr !== '0 || wdata !== 64'd0 || wstrb !== 8'd0) begin
            failures++;
            $display("FAIL reset_payload: ld=%h ar=%h aw=%h wd=%h ws=%h expected 0",
                     load_data, araddr, awaddr, wdata, wstrb);
        end
        memoryReadWen = 1'b1;
        #1;
        checks++;
        if (me_wait_for_axi !== 1'b1) begin
            failures++;
            $display("FAIL reset_wait_req: got %b expected 1", me_wait_for_axi);
        end
        memoryReadWen = 1'b0;
        #1;
        checks++;
        if (me_wait_for_axi !== 1'b0) begin
            failures++;
            $display("FAIL reset_wait_idle: got %b expected 0", me_wait_for_axi);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_byte_sext();
        int w; bit sa; int al; int wl; int bh;
        run_txn("load_byte", 64'h8000_0003, 1'b1, 4'd1, 1'b1, 8'h00, 64'd0,
                64'h0000_0000_8000_0000, 2'b00, 0, 0, 0, 0, 0,
                mk(1'b1, 32'h8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 1'b0),
                w, sa, al, wl, bh);
        checks++;
        if (w !== 3) begin
            failures++;
            $display("FAIL load_byte wait_cycles: got %0d expected 3", w);
        end
    endtask

    task automatic test_store_delayed_w();
        int w; bit sa; int al; int wl; int bh;
        run_txn("store_w_late", 64'h8000_0004, 1'b0, 4'd0, 1'b0, 8'hF0, 64'h1122_3344,
                64'd0, 2'b00, 0, 0, 0, 2, 0,
                mk(1'b0, 32'h8000_0000, 64'h1122_3344_0000_0000, 8'hF0, 1'b0),
                w, sa, al, wl, bh);
        checks++;
        if (!(al >= 0 && al < wl)) begin
            failures++;
            $display("FAIL store_w_late order: aw_last=%0d w_last=%0d expected aw before w", al, wl);
        end
        checks++;
        if (bh !== 1) begin
            failures++;
            $display("FAIL store_w_late b_handshakes: got %0d expected 1", bh);
        end
        checks++;
        if (w !== 5) begin
            failures++;
            $display("FAIL store_w_late wait_cycles: got %0d expected 5", w);
        end
    endtask

    task automatic test_store_zero_wait();
        int w; bit sa; int al; int wl; int bh;
        run_txn("store_fast", 64'h8000_0011, 1'b0, 4'd0, 1'b0, 8'h02, 64'h0000_00A5,
                64'd0, 2'b00, 0, 0, 0, 0, 0,
                mk(1'b0, 32'h8000_0010, 64'h0000_0000_0000_A500, 8'h02, 1'b0),
                w, sa, al, wl, bh);
        checks++;
        if (w !== 3 || bh !== 1) begin
            failures++;
            $display("FAIL store_fast wait/b: got %0d/%0d expected 3/1", w, bh);
        end
    endtask

    task automatic test_load_slow_slave();
        int w; bit sa; int al; int wl; int bh;
        run_txn("load_slow", 64'h8000_0104, 1'b1, 4'd4, 1'b0, 8'h00, 64'd0,
                64'hDEAD_BEEF_FFFF_FFFF, 2'b00, 3, 2, 0, 0, 0,
                mk(1'b1, 32'h8000_0100, 64'h0000_0000_DEAD_BEEF, 8'h00, 1'b0),
                w, sa, al, wl, bh);
        checks++;
        if (w !== 8) begin
            failures++;
            $display("FAIL load_slow wait_cycles: got %0d expected 8", w);
        end
    endtask

    task automatic test_read_error();
        int w; bit sa; int al; int wl; int bh;
        run_txn("read_err", 64'h8000_0010, 1'b1, 4'd8, 1'b0, 8'h00, 64'd0,
                64'h1234_5678_9ABC_DEF0, 2'b10, 0, 0, 0, 0, 0,
                mk(1'b1, 32'h8000_0010, 64'd0, 8'h00, 1'b1),
                w, sa, al, wl, bh);
        checks++;
        if (w !== 3) begin
            failures++;
            $display("FAIL read_err wait_cycles: got %0d expected 3", w);
        end
    endtask

    task automatic test_write_error();
        int w; bit sa; int al; int wl; int bh;
        run_txn("write_err", 64'h8000_0020, 1'b0, 4'd0, 1'b0, 8'hFF, 64'hCAFE_F00D_0BAD_BEEF,
                64'd0, 2'b10, 0, 0, 1, 0, 1,
                mk(1'b0, 32'h8000_0020, 64'hCAFE_F00D_0BAD_BEEF, 8'hFF, 1'b1),
                w, sa, al, wl, bh);
        checks++;
        if (bh !== 1) begin
            failures++;
            $display("FAIL write_err b_handshakes: got %0d expected 1", bh);
        end
    endtask

    task automatic test_read_precedence();
        int w; bit sa; int al; int wl; int bh;
        run_txn("read_wins", 64'h8000_0008, 1'b1, 4'd2, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h0000_0000_0000_8001, 2'b00, 0, 0, 0, 0, 0,
                mk(1'b1, 32'h8000_0008, 64'hFFFF_FFFF_FFFF_8001, 8'h00, 1'b0),
                w, sa, al, wl, bh);
        checks++;
        if (sa !== 1'b0 || bh !== 0) begin
            failures++;
            $display("FAIL read_wins no_write: saw_aw=%b b_hs=%0d expected 0/0", sa, bh);
        end
    endtask

    task automatic test_back_to_back();
        int w; bit sa; int al; int wl; int bh;
        run_txn("b2b_sext32", 64'h8000_0030, 1'b1, 4'd4, 1'b1, 8'h00, 64'd0,
                64'h0000_0000_F000_0000, 2'b00, 0, 0, 0, 0, 0,
                mk(1'b1, 32'h8000_0030, 64'hFFFF_FFFF_F000_0000, 8'h00, 1'b0),
                w, sa, al, wl, bh);
        run_txn("b2b_size3", 64'h8000_0038, 1'b1, 4'd3, 1'b0, 8'h00, 64'd0,
                64'h0123_4567_89AB_CDEF, 2'b00, 0, 1, 0, 0, 0,
                mk(1'b1, 32'h8000_0038, 64'h0123_4567_89AB_CDEF, 8'h00, 1'b0),
                w, sa, al, wl, bh);
        run_txn("b2b_half_zext", 64'h8000_0046, 1'b1, 4'd2, 1'b0, 8'h00, 64'd0,
                64'h9876_0000_0000_0000, 2'b00, 1, 0, 0, 0, 0,
                mk(1'b1, 32'h8000_0040, 64'h0000_0000_0000_9876, 8'h00, 1'b0),
                w, sa, al, wl, bh);
        checks++;
        if (w !== 4) begin
            failures++;
            $display("FAIL b2b_half_zext wait_cycles: got %0d expected 4", w);
        end
    endtask

    task automatic test_reset_mid_txn();
        int w; bit sa; int al; int wl; int bh;
        @(negedge clk);
        addr          = 64'h8000_0050;
        memoryReadWen = 1'b1;
        readNum       = 4'd8;
        @(negedge clk);
        arready = arvalid;
        @(negedge clk);
        arready = 1'b0;
        checks++;
        if (rready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid in_r: rready=%b expected 1", rready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready, load_valid, bus_err} !== 7'b0) begin
            failures++;
            $display("FAIL rst_mid outputs: got %b expected 0000000",
                     {arvalid, rready, awvalid, wvalid, bready, load_valid, bus_err});
        end
        clear_inputs();
        #1;
        checks++;
        if (me_wait_for_axi !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid idle_wait: got %b expected 0", me_wait_for_axi);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_txn("after_rst", 64'h8000_0061, 1'b1, 4'd1, 1'b0, 8'h00, 64'd0,
                64'h0000_0000_0000_AB00, 2'b00, 0, 0, 0, 0, 0,
                mk(1'b1, 32'h8000_0060, 64'h0000_0000_0000_00AB, 8'h00, 1'b0),
                w, sa, al, wl, bh);
        checks++;
        if (w !== 3) begin
            failures++;
            $display("FAIL after_rst wait_cycles: got %0d expected 3", w);
        end
    endtask

    initial begin
        test_reset();
        test_load_byte_sext();
        test_store_delayed_w();
        test_store_zero_wait();
        test_load_slow_slave();
        test_read_error();
        test_write_error();
        test_read_precedence();
        test_back_to_back();
        test_reset_mid_txn();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22041207_me_lsu.md
# ysyx_22041207_me_lsu

Memory-stage load/store unit. It consumes the memory-access fields held in the EX/ME pipeline register and runs one AXI4-Lite transaction per load or store as master. While a transaction is outstanding it asserts `me_wait_for_axi` so the EX/ME register holds its contents. It returns aligned, sign- or zero-extended load data to the ME/WB path.

## Interface
- `ADDR_W`, default 32: AXI address width. The low `ADDR_W` bits of `addr` are used.
- `clk` in 1: single clock. All state updates on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `addr` in 64: effective address (ALU result).
- `memoryReadWen` in 1: load request.
- `readNum` in 4: load size in bytes (1/2/4/8).
- `sext` in 1: sign-extend the load result.
- `memoryWriteMask` in 8: byte strobe, already shifted by `addr[2:0]`. Non-zero means store request.
- `wdata_in` in 64: store data (rs2), unshifted.
- `me_wait_for_axi` out 1: stall to the EX/ME register and upstream.
- `load_data` out 64: extended load result.
- `load_valid` out 1: one-cycle pulse when a load completes.
- `bus_err` out 1: one-cycle pulse when a completion carries a non-OKAY response.
- Read address channel: `araddr` out ADDR_W, `arvalid` out 1, `arready` in 1.
- Read data channel: `rdata` in 64, `rresp` in 2, `rvalid` in 1, `rready` out 1.
- Write address channel: `awaddr` out ADDR_W, `awvalid` out 1, `awready` in 1.
- Write data channel: `wdata` out 64, `wstrb` out 8, `wvalid` out 1, `wready` in 1.
- Write response channel: `bresp` in 2, `bvalid` in 1, `bready` out 1.

## Operation
- Request present: `req = memoryReadWen | (|memoryWriteMask)`.
- If both are set, the read takes precedence and the store is dropped.
- FSM states: IDLE, AR, R, AW_W, B, DONE.
- IDLE, load request: go to AR.
- IDLE, store request: go to AW_W.
- IDLE, no request: stay in IDLE.
- AR: `arvalid`=1. On `arready` go to R.
- R: `rready`=1. On `rvalid`, capture data and go to DONE.
- AW_W: `awvalid` and `wvalid` both start high.
  - Each drops independently after its own handshake, tracked with two done flags.
  - Go to B once both handshakes have completed, whether in the same cycle or in different cycles.
- B: `bready`=1. On `bvalid` go to DONE.
- DONE: lasts one cycle, then go to IDLE. `req` is ignored in DONE because it still shows the old instruction.
- Addresses are 8-byte aligned: `araddr` = `awaddr` = `{addr[ADDR_W-1:3],3'b0}`, registered when leaving IDLE.
- Store data: `wdata` = `wdata_in << (8*addr[2:0])`, `wstrb` = `memoryWriteMask`, both registered when leaving IDLE.
- Load data path:
  - Shift: `rdata >> (8*addr[2:0])`, using `addr[2:0]` registered when leaving IDLE.
  - Truncate to `readNum` bytes.
  - Extend to 64 bits, sign-extending if `sext`, zero-extending otherwise.
  - An unlisted `readNum` value is treated as 8.
- `load_data` is registered and holds until the next load completes.
- An access that crosses an 8-byte boundary is not supported; upstream guarantees alignment.
- `me_wait_for_axi` = `(state==IDLE & req) | state∈{AR,R,AW_W,B}`. It is combinational, and is low in DONE.
- Errors:
  - A non-zero `rresp` in R or `bresp` in B pulses `bus_err` during DONE.
  - For a read error, `load_data` is forced to 0.
  - A write error still pulses `bus_err`; `load_valid` stays 0.

## Timing
- Reset values: state IDLE; all `*valid`/`*ready` outputs 0; `load_data` 0; `load_valid`, `bus_err` 0; `araddr`, `awaddr`, `wdata`, `wstrb` 0. `me_wait_for_axi` follows `req` combinationally.
- The EX/ME register updates on negedge clk. Because `me_wait_for_axi` is low for the DONE cycle, the next instruction is loaded mid-DONE and sampled in the following IDLE cycle.
- Load with a zero-wait slave:
  - c0: IDLE with req, wait=1.
  - c1: AR, `arvalid`; `arready` arrives.
  - c2: R, `rready`; `rvalid` arrives.
  - c3: DONE, wait=0, `load_valid`=1.
  - Stall is 3 cycles; the next request can be accepted at c4.
- Store with a zero-wait slave:
  - c1: AW_W, both handshakes complete.
  - c2: B.
  - c3: DONE.
- Back-to-back requests cost one extra IDLE cycle each; no overlap between transactions.
- `valid` outputs never drop before their handshake, and their payloads stay stable while valid.
- Reset asserted mid-transaction: return to IDLE immediately. The outstanding AXI transaction is abandoned; the slave shares `rst_n`.

## Test plan
- Load, zero-wait slave, `addr`=0x80000003, `readNum`=1, `sext`=1, `rdata`=0x00000000_80000000 → `araddr`=0x80000000, `load_data`=0xFFFFFFFFFFFFFF80, wait high exactly 3 cycles.
- Store, `addr`=0x80000004, mask=0xF0, `wdata_in`=0x11223344; `wready` 2 cycles after `awready` → `wdata`=0x11223344_00000000, `wstrb`=0xF0; `awvalid` drops before `wvalid`; single B handshake.
- Load with `arready` delayed 3 cycles and `rvalid` delayed 2 cycles, `readNum`=4, `sext`=0, `rdata`=0xDEADBEEF_FFFFFFFF, `addr`[2:0]=4 → `load_data`=0x00000000DEADBEEF; `araddr` stable throughout.
- `rresp`=2'b10 → `bus_err` pulse, `load_data`=0, `load_valid`=1, FSM returns to IDLE.
- Both `memoryReadWen` and mask=0xFF set → read only, `awvalid` never asserted.
- `rst_n` low while in R → next edge shows IDLE, all valids 0; a fresh load after reset completes normally.
